load_queue: RTL and testbench

- Per-load-unit holding buffer between the load reservation-station issue and the FU completion select in the out-of-order core.
- Each entry computes its effective address and queries the store queue for forwarding.
- If forwarding fails, the entry requests the data cache and waits for hit or miss data.
- The entry then presents a completed result to the FU select logic until it is chosen.

---
 rtl/load_queue_pkg.sv | 70 +++++++
 rtl/load_queue_data_extract.sv | 35 +++
 rtl/load_queue.sv | 231 +++++++++++++++++++++++
 tb/tb_load_queue.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_queue_pkg.sv
// Shared constants, bus payloads and entry state for the load queue.
package load_queue_pkg;

    localparam int unsigned NUM_FU_LOAD   = 2;
    localparam int unsigned LU_LEN        = NUM_FU_LOAD;
    localparam int unsigned NUM_LU_DCACHE = 1;
    localparam int unsigned N             = 2;
    localparam int unsigned SQ_IDX_BITS   = 3;
    localparam int unsigned PRN_BITS      = 6;
    localparam int unsigned ROB_BITS      = 5;
    localparam int unsigned XLEN          = 32;
    localparam int unsigned MEM_FUNC_BITS = 3;
    localparam int unsigned LQ_IDX_BITS   = (NUM_FU_LOAD > 1) ? $clog2(NUM_FU_LOAD) : 1;

    typedef logic [MEM_FUNC_BITS-1:0] mem_func_t;

    localparam mem_func_t FUNC_LB  = 3'b000;
    localparam mem_func_t FUNC_LH  = 3'b001;
    localparam mem_func_t FUNC_LW  = 3'b010;
    localparam mem_func_t FUNC_LBU = 3'b100;
    localparam mem_func_t FUNC_LHU = 3'b101;

    typedef enum logic [2:0] {
        LQ_EMPTY = 3'd0,
        LQ_ADDR  = 3'd1,
        LQ_REQ   = 3'd2,
        LQ_WAIT  = 3'd3,
        LQ_READY = 3'd4
    } load_state_t;

    typedef struct packed {
        logic                   valid;
        logic [XLEN-1:0]        base;
        logic [XLEN-1:0]        offset;
        mem_func_t              func;
        logic [PRN_BITS-1:0]    dest_prn;
        logic [ROB_BITS-1:0]    robn;
        logic [SQ_IDX_BITS-1:0] sq_idx;
    } rs_lq_packet_t;

    typedef struct packed {
        logic                valid;
        logic [PRN_BITS-1:0] dest_prn;
        logic [ROB_BITS-1:0] robn;
        logic [XLEN-1:0]     result;
    } fu_packet_t;

    typedef struct packed {
        logic                   valid;
        logic [XLEN-1:0]        addr;
        logic [LQ_IDX_BITS-1:0] lq_idx;
    } lq_dcache_packet_t;

    typedef struct packed {
        logic                   valid;
        logic [LQ_IDX_BITS-1:0] lq_idx;
        logic [XLEN-1:0]        data;
    } dcache_lq_packet_t;

    // Per-entry payload held while the load is in flight.
    typedef struct packed {
        logic [XLEN-1:0]        addr;
        mem_func_t              func;
        logic [PRN_BITS-1:0]    dest_prn;
        logic [ROB_BITS-1:0]    robn;
        logic [SQ_IDX_BITS-1:0] sq_idx;
        logic [XLEN-1:0]        result;
    } lq_entry_t;

endpackage

// File: rtl/load_queue_data_extract.sv
// Combinational RV32 load extraction: picks the byte/half/word lane and extends it.
module load_data_extract
    import load_queue_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      byte_off,
    input  mem_func_t       func,
    output logic [XLEN-1:0] result_c
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[7:0];
        case (byte_off)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = byte_off[1] ? word[31:16] : word[15:0];

        result_c = word;
        case (func)
            FUNC_LB:  result_c = {{24{lane_b[7]}}, lane_b};
            FUNC_LH:  result_c = {{16{lane_h[15]}}, lane_h};
            FUNC_LW:  result_c = word;
            FUNC_LBU: result_c = {24'd0, lane_b};
            FUNC_LHU: result_c = {16'd0, lane_h};
            default:  result_c = word;
        endcase
    end

endmodule

// File: rtl/load_queue.sv
// Load queue: per-entry address/forward/dcache/complete sequencing for the load units.
// Optional LQ_DEBUG_EN adds lq_state_dbg and per-transition trace messages.
module load_queue
    import load_queue_pkg::*;
(
    input  logic                                      clock,
    input  logic                                      reset,
    input  rs_lq_packet_t     [NUM_FU_LOAD-1:0]       rs_lq_packet,
    output logic              [NUM_FU_LOAD-1:0]       load_rs_avail,
    input  logic              [LU_LEN-1:0]            load_selected,
    output logic              [LU_LEN-1:0]            load_prepared,
    output fu_packet_t        [LU_LEN-1:0]            load_packet,
    output logic              [NUM_FU_LOAD-1:0][XLEN-1:0] sq_addr,
    output logic              [NUM_FU_LOAD-1:0][SQ_IDX_BITS-1:0] store_range,
    output mem_func_t         [NUM_FU_LOAD-1:0]       load_byte_info,
    input  logic              [NUM_FU_LOAD-1:0][XLEN-1:0] value,
    input  logic              [NUM_FU_LOAD-1:0]       fwd_valid,
    input  dcache_lq_packet_t [N-1:0]                 dcache_lq_packet,
    input  logic              [NUM_LU_DCACHE-1:0]     load_req_accept,
    input  logic              [NUM_LU_DCACHE-1:0][XLEN-1:0] load_req_data,
    input  logic              [NUM_LU_DCACHE-1:0]     load_req_data_valid,
    output lq_dcache_packet_t [NUM_LU_DCACHE-1:0]     lq_dcache_packet
`ifdef LQ_DEBUG_EN
    ,
    output logic              [NUM_FU_LOAD-1:0][2:0]  lq_state_dbg
`endif
);

    load_state_t state_q [NUM_FU_LOAD];
    load_state_t state_d [NUM_FU_LOAD];
    lq_entry_t   entry_q [NUM_FU_LOAD];
    lq_entry_t   entry_d [NUM_FU_LOAD];

    logic [NUM_FU_LOAD-1:0][XLEN-1:0] raw_word;
    logic [NUM_FU_LOAD-1:0][XLEN-1:0] extracted;
    logic [NUM_FU_LOAD-1:0]           req_accept;
    logic [NUM_FU_LOAD-1:0]           req_hit;
    logic [NUM_FU_LOAD-1:0]           ret_hit;

    logic              [NUM_FU_LOAD-1:0]                  rs_avail_d;
    logic              [LU_LEN-1:0]                       prepared_d;
    fu_packet_t        [LU_LEN-1:0]                       packet_d;
    logic              [NUM_FU_LOAD-1:0][XLEN-1:0]        sq_addr_d;
    logic              [NUM_FU_LOAD-1:0][SQ_IDX_BITS-1:0] store_range_d;
    mem_func_t         [NUM_FU_LOAD-1:0]                  byte_info_d;
    lq_dcache_packet_t [NUM_LU_DCACHE-1:0]                dc_pkt_d;
    logic              [NUM_FU_LOAD-1:0]                  req_left;
    logic                                                 found;

    // Data source per entry: forwarded word, same-cycle hit data, or broadcast miss data.
    always_comb begin
        for (int unsigned i = 0; i < NUM_FU_LOAD; i++) begin
            raw_word[i]   = '0;
            req_accept[i] = 1'b0;
            req_hit[i]    = 1'b0;
            ret_hit[i]    = 1'b0;
            case (state_q[i])
                LQ_ADDR: raw_word[i] = value[i];
                LQ_REQ: begin
                    for (int unsigned k = 0; k < NUM_LU_DCACHE; k++) begin
                        if (lq_dcache_packet[k].valid && load_req_accept[k] &&
                            lq_dcache_packet[k].lq_idx == LQ_IDX_BITS'(i)) begin
                            req_accept[i] = 1'b1;
                            req_hit[i]    = load_req_data_valid[k];
                            raw_word[i]   = load_req_data[k];
                        end
                    end
                end
                LQ_WAIT: begin
                    // Scan high to low so the lowest matching port wins.
                    for (int j = int'(N) - 1; j >= 0; j--) begin
                        if (dcache_lq_packet[j].valid &&
                            dcache_lq_packet[j].lq_idx == LQ_IDX_BITS'(i)) begin
                            ret_hit[i]  = 1'b1;
                            raw_word[i] = dcache_lq_packet[j].data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_FU_LOAD; g++) begin : g_extract
        load_data_extract u_extract (
            .word     (raw_word[g]),
            .byte_off (entry_q[g].addr[1:0]),
            .func     (entry_q[g].func),
            .result_c (extracted[g])
        );
    end

    // Next state, entry payload and next-cycle output values.
    always_comb begin
        rs_avail_d    = '0;
        prepared_d    = '0;
        packet_d      = '0;
        sq_addr_d     = '0;
        store_range_d = '0;
        byte_info_d   = '0;
        dc_pkt_d      = '0;
        req_left      = '0;
        found         = 1'b0;

        for (int unsigned i = 0; i < NUM_FU_LOAD; i++) begin
            state_d[i] = state_q[i];
            entry_d[i] = entry_q[i];

            case (state_q[i])
                LQ_EMPTY: begin
                    if (rs_lq_packet[i].valid) begin
                        entry_d[i].addr     = rs_lq_packet[i].base + rs_lq_packet[i].offset;
                        entry_d[i].func     = rs_lq_packet[i].func;
                        entry_d[i].dest_prn = rs_lq_packet[i].dest_prn;
                        entry_d[i].robn     = rs_lq_packet[i].robn;
                        entry_d[i].sq_idx   = rs_lq_packet[i].sq_idx;
                        entry_d[i].result   = '0;
                        state_d[i]          = LQ_ADDR;
                    end
                end
                LQ_ADDR: begin
                    if (fwd_valid[i]) begin
                        entry_d[i].result = extracted[i];
                        state_d[i]        = LQ_READY;
                    end else begin
                        state_d[i] = LQ_REQ;
                    end
                end
                LQ_REQ: begin
                    if (req_accept[i]) begin
                        if (req_hit[i]) begin
                            entry_d[i].result = extracted[i];
                            state_d[i]        = LQ_READY;
                        end else begin
                            state_d[i] = LQ_WAIT;
                        end
                    end
                end
                LQ_WAIT: begin
                    if (ret_hit[i]) begin
                        entry_d[i].result = extracted[i];
                        state_d[i]        = LQ_READY;
                    end
                end
                LQ_READY: begin
                    if (load_selected[i]) begin
                        state_d[i] = LQ_EMPTY;
                    end
                end
                default: state_d[i] = LQ_EMPTY;
            endcase

            rs_avail_d[i] = (state_d[i] == LQ_EMPTY);
            req_left[i]   = (state_d[i] == LQ_REQ);
            if (state_d[i] == LQ_ADDR) begin
                sq_addr_d[i]     = entry_d[i].addr;
                store_range_d[i] = entry_d[i].sq_idx;
                byte_info_d[i]   = entry_d[i].func;
            end
            if (state_d[i] == LQ_READY) begin
                prepared_d[i]        = 1'b1;
                packet_d[i].valid    = 1'b1;
                packet_d[i].dest_prn = entry_d[i].dest_prn;
                packet_d[i].robn     = entry_d[i].robn;
                packet_d[i].result   = entry_d[i].result;
            end
        end

        // Port k takes the k-th lowest-index entry that will be in REQ.
        for (int unsigned k = 0; k < NUM_LU_DCACHE; k++) begin
            found = 1'b0;
            for (int unsigned i = 0; i < NUM_FU_LOAD; i++) begin
                if (!found && req_left[i]) begin
                    found              = 1'b1;
                    req_left[i]        = 1'b0;
                    dc_pkt_d[k].valid  = 1'b1;
                    dc_pkt_d[k].addr   = {entry_d[i].addr[XLEN-1:2], 2'b00};
                    dc_pkt_d[k].lq_idx = LQ_IDX_BITS'(i);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_FU_LOAD; i++) begin
                state_q[i] <= LQ_EMPTY;
                entry_q[i] <= '0;
            end
            load_rs_avail    <= '1;
            load_prepared    <= '0;
            load_packet      <= '0;
            sq_addr          <= '0;
            store_range      <= '0;
            load_byte_info   <= '0;
            lq_dcache_packet <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU_LOAD; i++) begin
                state_q[i] <= state_d[i];
                entry_q[i] <= entry_d[i];
            end
            load_rs_avail    <= rs_avail_d;
            load_prepared    <= prepared_d;
            load_packet      <= packet_d;
            sq_addr          <= sq_addr_d;
            store_range      <= store_range_d;
            load_byte_info   <= byte_info_d;
            lq_dcache_packet <= dc_pkt_d;
        end
    end

`ifdef LQ_DEBUG_EN
    always_comb begin
        for (int unsigned i = 0; i < NUM_FU_LOAD; i++) begin
            lq_state_dbg[i] = 3'(state_q[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_FU_LOAD; i++) begin
                if (state_d[i] != state_q[i]) begin
                    $display("load_queue entry %0d: %s -> %s", i,
                             state_q[i].name(), state_d[i].name());
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_load_queue.sv
// Self-checking bench for load_queue: directed scenarios plus randomized loads
// checked against a shift-based reference of the RV32 load rules.
module tb_load_queue;
    import load_queue_pkg::*;

    logic                                      clock;
    logic                                      reset;
    rs_lq_packet_t     [NUM_FU_LOAD-1:0]       rs_lq_packet;
    logic              [NUM_FU_LOAD-1:0]       load_rs_avail;
    logic              [LU_LEN-1:0]            load_selected;
    logic              [LU_LEN-1:0]            load_prepared;
    fu_packet_t        [LU_LEN-1:0]            load_packet;
    logic              [NUM_FU_LOAD-1:0][31:0] sq_addr;
    logic              [NUM_FU_LOAD-1:0][SQ_IDX_BITS-1:0] store_range;
    mem_func_t         [NUM_FU_LOAD-1:0]       load_byte_info;
    logic              [NUM_FU_LOAD-1:0][31:0] value;
    logic              [NUM_FU_LOAD-1:0]       fwd_valid;
    dcache_lq_packet_t [N-1:0]                 dcache_lq_packet;
    logic              [NUM_LU_DCACHE-1:0]     load_req_accept;
    logic              [NUM_LU_DCACHE-1:0][31:0] load_req_data;
    logic              [NUM_LU_DCACHE-1:0]     load_req_data_valid;
    lq_dcache_packet_t [NUM_LU_DCACHE-1:0]     lq_dcache_packet;

    int errors = 0;
    int checks = 0;
    mem_func_t funcs [5];

    load_queue dut (
        .clock               (clock),
        .reset               (reset),
        .rs_lq_packet        (rs_lq_packet),
        .load_rs_avail       (load_rs_avail),
        .load_selected       (load_selected),
        .load_prepared       (load_prepared),
        .load_packet         (load_packet),
        .sq_addr             (sq_addr),
        .store_range         (store_range),
        .load_byte_info      (load_byte_info),
        .value               (value),
        .fwd_valid           (fwd_valid),
        .dcache_lq_packet    (dcache_lq_packet),
        .load_req_accept     (load_req_accept),
        .load_req_data       (load_req_data),
        .load_req_data_valid (load_req_data_valid),
        .lq_dcache_packet    (lq_dcache_packet)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Reference: shift the word so the addressed byte is at bit 0, then extend.
    function automatic logic [31:0] model_extract(input mem_func_t f, input logic [31:0] a,
                                                  input logic [31:0] w);
        logic [31:0] s;
        s = w >> (32'(a[1:0]) * 32'd8);
        case (f)
            3'b000:  return 32'($signed(s[7:0]));
            3'b001:  return 32'($signed(s[15:0]));
            3'b100:  return 32'(s[7:0]);
            3'b101:  return 32'(s[15:0]);
            default: return w;
        endcase
    endfunction

    function automatic fu_packet_t model_packet(input logic [5:0] prn, input logic [4:0] rob,
                                                input logic [31:0] res);
        fu_packet_t p;
        p.valid = 1'b1; p.dest_prn = prn; p.robn = rob; p.result = res;
        return p;
    endfunction

    function automatic lq_dcache_packet_t model_req(input logic [31:0] a, input int e);
        lq_dcache_packet_t p;
        p.valid = 1'b1; p.addr = a & 32'hFFFF_FFFC; p.lq_idx = LQ_IDX_BITS'(e);
        return p;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        rs_lq_packet = '0; load_selected = '0; value = '0; fwd_valid = '0;
        dcache_lq_packet = '0; load_req_accept = '0; load_req_data = '0;
        load_req_data_valid = '0;
    endtask

    task automatic issue(input int e, input logic [31:0] base, input logic [31:0] off,
                         input mem_func_t f, input logic [5:0] prn, input logic [4:0] rob,
                         input logic [2:0] sq);
        rs_lq_packet[e].valid    = 1'b1;
        rs_lq_packet[e].base     = base;
        rs_lq_packet[e].offset   = off;
        rs_lq_packet[e].func     = f;
        rs_lq_packet[e].dest_prn = prn;
        rs_lq_packet[e].robn     = rob;
        rs_lq_packet[e].sq_idx   = sq;
        tick();
        rs_lq_packet = '0;
    endtask

    task automatic release_all();
        load_selected = 2'b11;
        tick();
        load_selected = '0;
        checks++;
        if (load_rs_avail !== 2'b11) begin
            errors++; $display("FAIL release_avail: got %b required 11", load_rs_avail);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (load_rs_avail !== 2'b11) begin
            errors++; $display("FAIL reset_avail: got %b required 11", load_rs_avail);
        end
        checks++;
        if (load_prepared !== 2'b00 || load_packet !== '0) begin
            errors++; $display("FAIL reset_prepared: got %b/%h required 0", load_prepared, load_packet);
        end
        checks++;
        if (lq_dcache_packet[0].valid !== 1'b0 || sq_addr !== '0 || store_range !== '0 ||
            load_byte_info !== '0) begin
            errors++; $display("FAIL reset_outputs: got dc=%b sq=%h required all 0",
                               lq_dcache_packet[0].valid, sq_addr);
        end
    endtask

    task automatic test_forward();
        issue(0, 32'h100, 32'h4, FUNC_LW, 6'd5, 5'd7, 3'd3);
        checks++;
        if (sq_addr[0] !== 32'h104 || load_byte_info[0] !== FUNC_LW || store_range[0] !== 3'd3) begin
            errors++; $display("FAIL fwd_addr: got %h/%b/%0d required 104/010/3",
                               sq_addr[0], load_byte_info[0], store_range[0]);
        end
        checks++;
        if (load_rs_avail !== 2'b10) begin
            errors++; $display("FAIL fwd_avail: got %b required 10", load_rs_avail);
        end
        value[0] = 32'hDEAD_BEEF; fwd_valid[0] = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (load_prepared !== 2'b01 || load_packet[0] !== model_packet(6'd5, 5'd7, 32'hDEAD_BEEF)) begin
            errors++; $display("FAIL fwd_result: got %b/%h required 01/%h", load_prepared,
                               load_packet[0], model_packet(6'd5, 5'd7, 32'hDEAD_BEEF));
        end
        checks++;
        if (sq_addr[0] !== 32'h0) begin
            errors++; $display("FAIL fwd_sq_clear: got %h required 0", sq_addr[0]);
        end
        release_all();
        checks++;
        if (load_prepared !== 2'b00 || load_packet[0].valid !== 1'b0) begin
            errors++; $display("FAIL fwd_release: got %b required 00", load_prepared);
        end
    endtask

    task automatic cache_hit_case(input string name, input mem_func_t f, input logic [31:0] expect_val);
        issue(0, 32'h100, 32'h3, f, 6'd9, 5'd2, 3'd1);
        tick();
        checks++;
        if (lq_dcache_packet[0] !== model_req(32'h103, 0)) begin
            errors++; $display("FAIL %s_req: got %h required %h", name, lq_dcache_packet[0],
                               model_req(32'h103, 0));
        end
        load_req_accept[0] = 1'b1; load_req_data_valid[0] = 1'b1; load_req_data[0] = 32'h80FF_FFFF;
        tick();
        clear_inputs();
        checks++;
        if (load_prepared !== 2'b01 || load_packet[0].result !== expect_val) begin
            errors++; $display("FAIL %s_result: got %b/%h required 01/%h", name, load_prepared,
                               load_packet[0].result, expect_val);
        end
        release_all();
    endtask

    task automatic test_cache_hit();
        cache_hit_case("lb", FUNC_LB, 32'hFFFF_FF80);
        cache_hit_case("lbu", FUNC_LBU, 32'h0000_0080);
    endtask

    task automatic test_miss();
        issue(0, 32'h200, 32'h2, FUNC_LHU, 6'd12, 5'd20, 3'd0);
        tick();
        load_req_accept[0] = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (lq_dcache_packet[0].valid !== 1'b0 || load_prepared !== 2'b00) begin
            errors++; $display("FAIL miss_wait: got dc=%b prep=%b required 0/00",
                               lq_dcache_packet[0].valid, load_prepared);
        end
        tick();
        dcache_lq_packet[1].valid = 1'b1; dcache_lq_packet[1].lq_idx = 1'b0;
        dcache_lq_packet[1].data = 32'hABCD_1234;
        tick();
        clear_inputs();
        checks++;
        if (load_prepared !== 2'b01 || load_packet[0] !== model_packet(6'd12, 5'd20, 32'h0000_ABCD)) begin
            errors++; $display("FAIL miss_result: got %b/%h required 01/0000abcd", load_prepared,
                               load_packet[0].result);
        end
        release_all();
    endtask

    task automatic test_back_to_back();
        rs_lq_packet[1].valid = 1'b1; rs_lq_packet[1].base = 32'h300; rs_lq_packet[1].offset = 32'h10;
        rs_lq_packet[1].func = FUNC_LW; rs_lq_packet[1].dest_prn = 6'd33; rs_lq_packet[1].robn = 5'd4;
        issue(0, 32'h400, 32'h8, FUNC_LW, 6'd31, 5'd3, 3'd2);
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (lq_dcache_packet[0] !== model_req(32'h408, 0)) begin
                errors++; $display("FAIL b2b_retry%0d: got %h required %h", c, lq_dcache_packet[0],
                                   model_req(32'h408, 0));
            end
            tick();
        end
        load_req_accept[0] = 1'b1;
        tick();
        checks++;
        if (lq_dcache_packet[0] !== model_req(32'h310, 1)) begin
            errors++; $display("FAIL b2b_second: got %h required %h", lq_dcache_packet[0],
                               model_req(32'h310, 1));
        end
        load_req_data_valid[0] = 1'b1; load_req_data[0] = 32'h1111_2222;
        tick();
        clear_inputs();
        checks++;
        if (load_prepared !== 2'b10 || load_packet[1] !== model_packet(6'd33, 5'd4, 32'h1111_2222)) begin
            errors++; $display("FAIL b2b_hit1: got %b/%h required 10/11112222", load_prepared,
                               load_packet[1].result);
        end
        dcache_lq_packet[0].valid = 1'b1; dcache_lq_packet[0].lq_idx = 1'b0; dcache_lq_packet[0].data = 32'hAAAA_0001;
        dcache_lq_packet[1].valid = 1'b1; dcache_lq_packet[1].lq_idx = 1'b0; dcache_lq_packet[1].data = 32'hBBBB_0002;
        tick();
        clear_inputs();
        checks++;
        if (load_prepared !== 2'b11 || load_packet[0].result !== 32'hAAAA_0001) begin
            errors++; $display("FAIL b2b_lowest_port: got %b/%h required 11/aaaa0001", load_prepared,
                               load_packet[0].result);
        end
        release_all();
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int e, path, delay, j;
            mem_func_t f;
            logic [31:0] a, base, word;
            logic [5:0] prn;
            logic [4:0] rob;
            e = int'($urandom_range(0, 1));
            f = funcs[$urandom_range(0, 4)];
            a = $urandom; base = $urandom; word = $urandom;
            if (f == FUNC_LW) a[1:0] = 2'b00;
            if (f == FUNC_LH || f == FUNC_LHU) a[0] = 1'b0;
            prn = 6'($urandom); rob = 5'($urandom);
            issue(e, base, a - base, f, prn, rob, 3'($urandom));
            checks++;
            if (sq_addr[e] !== a || load_byte_info[e] !== f) begin
                errors++; $display("FAIL rnd%0d_addr: got %h/%b required %h/%b", n, sq_addr[e],
                                   load_byte_info[e], a, f);
            end
            path = int'($urandom_range(0, 2));
            if (path == 0) begin
                value[e] = word; fwd_valid[e] = 1'b1;
                tick();
            end else begin
                value[e] = $urandom;
                tick();
                delay = int'($urandom_range(0, 3));
                for (int c = 0; c <= delay; c++) begin
                    checks++;
                    if (lq_dcache_packet[0] !== model_req(a, e)) begin
                        errors++; $display("FAIL rnd%0d_req: got %h required %h", n,
                                           lq_dcache_packet[0], model_req(a, e));
                    end
                    if (c == delay) begin
                        load_req_accept[0] = 1'b1;
                        load_req_data_valid[0] = (path == 1);
                        load_req_data[0] = (path == 1) ? word : $urandom;
                    end
                    tick();
                end
                clear_inputs();
                if (path == 2) begin
                    delay = int'($urandom_range(0, 3));
                    for (int c = 0; c < delay; c++) begin
                        dcache_lq_packet[0].valid = 1'b1; dcache_lq_packet[0].lq_idx = LQ_IDX_BITS'(1 - e);
                        dcache_lq_packet[0].data = $urandom;
                        tick();
                        checks++;
                        if (load_prepared !== 2'b00) begin
                            errors++; $display("FAIL rnd%0d_wait: got %b required 00", n, load_prepared);
                        end
                    end
                    j = int'($urandom_range(0, 1));
                    dcache_lq_packet = '0;
                    dcache_lq_packet[j].valid = 1'b1; dcache_lq_packet[j].lq_idx = LQ_IDX_BITS'(e);
                    dcache_lq_packet[j].data = word;
                    tick();
                end
            end
            clear_inputs();
            checks++;
            if (load_prepared !== (2'b01 << e) ||
                load_packet[e] !== model_packet(prn, rob, model_extract(f, a, word))) begin
                errors++; $display("FAIL rnd%0d_result: got %b/%h required %b/%h", n, load_prepared,
                                   load_packet[e], 2'b01 << e,
                                   model_packet(prn, rob, model_extract(f, a, word)));
            end
            release_all();
        end
    endtask

    task automatic test_reset_mid();
        issue(0, 32'h500, 32'h0, FUNC_LW, 6'd1, 5'd1, 3'd0);
        tick();
        load_req_accept[0] = 1'b1;
        tick();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dcache_lq_packet[0].valid = 1'b1; dcache_lq_packet[0].lq_idx = 1'b0;
        dcache_lq_packet[0].data = 32'h1234_5678;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (load_rs_avail !== 2'b11 || load_prepared !== 2'b00 || load_packet !== '0) begin
            errors++; $display("FAIL reset_mid: got avail=%b prep=%b required 11/00",
                               load_rs_avail, load_prepared);
        end
    endtask

    initial begin
        funcs[0] = FUNC_LB; funcs[1] = FUNC_LH; funcs[2] = FUNC_LW;
        funcs[3] = FUNC_LBU; funcs[4] = FUNC_LHU;
        test_reset();
        test_forward();
        test_cache_hit();
        test_miss();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
